// File: rtl/io_pkg.sv
// Shared constants for the board IO path: read address decode and pin-group widths.
package io_pkg;

  localparam int SW_W            = 16;
  localparam int BTN_W           = 5;
  localparam int IO_ADDR_LED_BIT = 2;

  typedef enum logic [1:0] {
    IO_ADDR_NONE    = 2'b00,
    IO_ADDR_SW      = 2'b01,
    IO_ADDR_BTN     = 2'b10,
    IO_ADDR_BTN_EVT = 2'b11
  } io_addr_e;

endpackage

// File: rtl/io_input_conditioner_if.sv
// CPU-side IO read bus seen by the input conditioner.
// The CPU presents io_address every cycle; io_read_en marks a read whose side effects
// (read-to-clear of button events) apply; io_rd_data is the registered word for the
// address seen on the previous edge, valid regardless of io_read_en.
interface io_input_conditioner_if;
  logic [31:0] io_address;
  logic        io_read_en;
  logic [31:0] io_rd_data;

  modport master (output io_address, output io_read_en, input io_rd_data);
  modport slave  (input io_address, input io_read_en, output io_rd_data);
endinterface

// File: rtl/debounce_bit.sv
// One conditioned input: 2-flop synchroniser, tick-based stability counter and clean flop.
// rise is combinational and marks the edge at which clean goes 0->1.
module debounce_bit #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_clean;
  logic [CW-1:0] r_cnt;
  logic          w_commit;

  assign w_commit = tick && (r_sync2 != r_clean) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // Any tick that sees the clean value again restarts the count.
      if (tick) begin
        if (r_sync2 == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_clean <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign clean = r_clean;
  assign rise  = w_commit & r_sync2;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions slide switches and push buttons for the Risc32 IO read path:
// shared prescaler, 21 debounced bits, sticky read-to-clear button events, registered read mux.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  io_input_conditioner_if.slave  bus,
  input  logic [SW_W-1:0]        sw_raw,
  input  logic [BTN_W-1:0]       btn_raw,
  output logic [SW_W-1:0]        sw_clean,
  output logic [BTN_W-1:0]       btn_clean,
  output logic [BTN_W-1:0]       btn_events,
  output logic [BTN_W-1:0]       btn_pulse
);

  localparam int            NBITS    = SW_W + BTN_W;
  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]    r_div;
  logic             w_tick;
  logic [NBITS-1:0] w_raw;
  logic [NBITS-1:0] w_clean;
  logic [NBITS-1:0] w_rise;
  logic [BTN_W-1:0] w_btn_rise;
  logic [BTN_W-1:0] w_returned;
  logic [BTN_W-1:0] r_btn_events;
  logic [BTN_W-1:0] r_btn_pulse;
  logic [31:0]      r_rd_data;
  logic             w_evt_read;
  logic             w_unused;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Switches occupy bits [SW_W-1:0], buttons the bits above them.
  assign w_raw = {btn_raw, sw_raw};

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_db
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick),
      .raw   (w_raw[gi]),
      .clean (w_clean[gi]),
      .rise  (w_rise[gi])
    );
  end

  assign w_btn_rise = w_rise[NBITS-1:SW_W];
  assign w_evt_read = bus.io_read_en && (bus.io_address[1:0] == IO_ADDR_BTN_EVT);
  // Only flags visible in this read's returned word are cleared; same-edge rises survive.
  assign w_returned = w_evt_read ? r_btn_events : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_events <= '0;
      r_btn_pulse  <= '0;
      r_rd_data    <= '0;
    end else begin
      r_btn_events <= (r_btn_events & ~w_returned) | w_btn_rise;
      r_btn_pulse  <= w_btn_rise;
      case (io_addr_e'(bus.io_address[1:0]))
        IO_ADDR_NONE:    r_rd_data <= '0;
        IO_ADDR_SW:      r_rd_data <= {{(32-SW_W){1'b0}}, w_clean[SW_W-1:0]};
        IO_ADDR_BTN:     r_rd_data <= {{(32-BTN_W){1'b0}}, w_clean[NBITS-1:SW_W]};
        IO_ADDR_BTN_EVT: r_rd_data <= {{(32-BTN_W){1'b0}}, r_btn_events};
      endcase
    end
  end

  assign sw_clean        = w_clean[SW_W-1:0];
  assign btn_clean       = w_clean[NBITS-1:SW_W];
  assign btn_events      = r_btn_events;
  assign btn_pulse       = r_btn_pulse;
  assign bus.io_rd_data  = r_rd_data;

  assign w_unused = ^{bus.io_address[31:2], w_rise[SW_W-1:0]};

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with TICK_DIV=4, STABLE_TICKS=3.
module tb_io_input_conditioner;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int MAX_LAT      = 2 + STABLE_TICKS * TICK_DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] sw_raw;
  logic [4:0]  btn_raw;
  logic [15:0] sw_clean;
  logic [4:0]  btn_clean;
  logic [4:0]  btn_events;
  logic [4:0]  btn_pulse;

  io_input_conditioner_if bus ();

  io_input_conditioner #(.TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .sw_clean   (sw_clean),
    .btn_clean  (btn_clean),
    .btn_events (btn_events),
    .btn_pulse  (btn_pulse)
  );

  // Posedges since reset release; ticks fall on posedges where cyc is a multiple of TICK_DIV.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      0:       return {16'b0, sw_clean};
      1:       return {27'b0, btn_clean};
      2:       return {27'b0, btn_events};
      default: return {27'b0, btn_pulse};
    endcase
  endfunction

  // driver tasks
  task automatic issue_read(input logic [31:0] addr, input logic [31:0] exp);
    bus.io_address = addr;
    bus.io_read_en = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic collect(input string tag);
    logic [31:0] e;
    @(negedge clk);
    bus.io_read_en = 1'b0;
    e = exp_q.pop_front();
    chk(tag, bus.io_rd_data, e);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    issue_read(addr, exp);
    collect(tag);
  endtask

  task automatic wait_val(input string tag, input int sel, input logic [31:0] exp, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sig(sel) === exp) break;
    end
    chk(tag, sig(sel), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [10:0] acc;
    int          first;
    int          pcnt;
    int          t1;
    int          t3;

    sw_raw         = '0;
    btn_raw        = '0;
    bus.io_address = '0;
    bus.io_read_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {1'b0, sw_clean, btn_clean, btn_events, btn_pulse}, 32'h0);
    chk("rst_rd", bus.io_rd_data, 32'h0);
    rst_n = 1'b1;

    // Reach a non-zero state, then reset asynchronously mid-count.
    sw_raw = 16'hFFFF;
    wait_val("sw_ffff", 0, 32'hFFFF, MAX_LAT);
    do_read("rd_sw_ffff", 32'h1, 32'h0000FFFF);
    sw_raw = 16'h0000;
    repeat (5) @(negedge clk);
    sw_raw = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {1'b0, sw_clean, btn_clean, btn_events, btn_pulse}, 32'h0);
    chk("async_rst_rd", bus.io_rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_val("rst_rel_sw", 0, 32'hFFFF, MAX_LAT);

    // Glitch: 6 cycles high can cover at most 2 ticks.
    @(negedge clk);
    btn_raw[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc |= {btn_clean[0], btn_pulse, btn_events};
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc |= {btn_clean[0], btn_pulse, btn_events};
    end
    chk("glitch_reject", 32'(acc), 32'h0);

    // Clean press of button 2.
    btn_raw[2] = 1'b1;
    first = 0;
    pcnt  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first == 0 && btn_clean == 5'b00100) first = i;
      if (btn_pulse[2]) pcnt++;
    end
    chk("press_latency_ok", 32'(first >= 1 && first <= MAX_LAT), 32'h1);
    chk("press_pulse_cycles", 32'(pcnt), 32'h1);
    chk("press_event", sig(2), 32'h4);
    do_read("rd_evt_press", 32'h3, 32'h4);
    chk("evt_cleared", sig(2), 32'h0);
    btn_raw[2] = 1'b0;
    wait_val("rel_btn2", 1, 32'h0, MAX_LAT);
    chk("no_evt_on_fall", sig(2), 32'h0);

    // Switch read and address decode.
    sw_raw     = 16'hA5C3;
    btn_raw[3] = 1'b1;
    wait_val("sw_a5c3", 0, 32'hA5C3, MAX_LAT);
    wait_val("btn3_clean", 1, 32'h8, MAX_LAT);
    do_read("rd_sw", 32'h1, 32'h0000A5C3);
    do_read("rd_sw_hi_addr", 32'hFFFF_FFF1, 32'h0000A5C3);
    do_read("rd_none", 32'h0, 32'h0);
    do_read("rd_btn", 32'h2, 32'h8);
    do_read("rd_evt3", 32'h3, 32'h8);
    chk("evt3_cleared", sig(2), 32'h0);
    btn_raw[3] = 1'b0;
    wait_val("rel_btn3", 1, 32'h0, MAX_LAT);

    // Read/rise collision: button 1 rises on the same edge as an address-3 read.
    btn_raw[0] = 1'b1;
    wait_val("evt0_set", 2, 32'h1, MAX_LAT);
    btn_raw[1] = 1'b1;
    t1 = cyc + 3;
    while (t1 % TICK_DIV != 0) t1++;
    t3 = t1 + (STABLE_TICKS - 1) * TICK_DIV;
    while (cyc < t3 - 1) @(negedge clk);
    issue_read(32'h3, 32'h1);
    collect("rd_collide_1");
    chk("evt_after_collide", sig(2), 32'h2);
    chk("pulse_collide", sig(3), 32'h2);
    do_read("rd_collide_2", 32'h3, 32'h2);
    chk("evt_after_collide_2", sig(2), 32'h0);
    btn_raw = '0;
    wait_val("rel_all", 1, 32'h0, MAX_LAT);

    // Two buttons at once; one read clears both.
    btn_raw = 5'b10001;
    wait_val("evt_multi", 2, 32'h11, MAX_LAT);
    do_read("rd_multi", 32'h3, 32'h11);
    chk("evt_multi_clr", sig(2), 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
